// File: rtl/i2c_master.sv
// i2c_master: single-shot I2C write master (START, address, ACK, data, ACK, STOP, then idle)
`timescale 1ns/1ps
module i2c_master #(
   parameter int QDIV = 25
) (
   input  logic       clk100mhz,
   input  logic       res,
   inout  wire        sda,
   output logic       scl,
   input  logic [7:0] data_to_send,
   input  logic [7:0] addr_to_send,
   output logic       clk2mhz_dummy
);
   localparam int CW = $clog2(QDIV);
   localparam logic [CW-1:0] LAST = CW'(QDIV - 1);
   typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE} state_t;
   state_t state, state_d;
   logic [CW-1:0] cnt;
   logic [1:0] q, q_d;
   logic [2:0] bit_cnt, bit_d;
   logic [7:0] addr_sh, data_sh;
   logic tick, ack, ack_d, scl_d, sda_low, sda_low_d, cur_bit, bit_phase;
   assign tick = cnt == LAST;
   assign sda = sda_low ? 1'b0 : 1'bz;
   // quarter-bit tick generator plus the debug square wave it toggles
   always_ff @(posedge clk100mhz or negedge res)
      if (!res) begin
         cnt <= '0;
         clk2mhz_dummy <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         clk2mhz_dummy <= clk2mhz_dummy ^ tick;
      end
   // next bus state and the scl/sda levels of the quarter it begins
   always_comb begin
      state_d = state;
      bit_d = bit_cnt;
      ack_d = ack;
      q_d = (state == IDLE) ? 2'd0 : q + 2'd1;
      case (state)
         IDLE: state_d = START;
         START: if (q == 2'd3) begin
            state_d = ADDR;
            bit_d = 3'd7;
         end
         ADDR: if (q == 2'd3) begin
            if (bit_cnt == 3'd0) state_d = ADDR_ACK;
            else bit_d = bit_cnt - 3'd1;
         end
         ADDR_ACK: begin
            if (q == 2'd2) ack_d = (sda === 1'b0);
            if (q == 2'd3) begin
               state_d = ack ? DATA : STOP;
               bit_d = 3'd7;
            end
         end
         DATA: if (q == 2'd3) begin
            if (bit_cnt == 3'd0) state_d = DATA_ACK;
            else bit_d = bit_cnt - 3'd1;
         end
         DATA_ACK: if (q == 2'd3) state_d = STOP;
         STOP: if (q == 2'd3) state_d = DONE;
         default: state_d = DONE;
      endcase
      cur_bit = (state_d == DATA) ? data_sh[bit_d] : addr_sh[bit_d];
      bit_phase = state_d inside {ADDR, ADDR_ACK, DATA, DATA_ACK};
      scl_d = bit_phase ? (q_d == 2'd1 || q_d == 2'd2) :
              (state_d == START) ? (q_d != 2'd3) :
              (state_d == STOP) ? (q_d != 2'd0) : 1'b1;
      sda_low_d = (state_d == START) ? (q_d != 2'd0) :
                  (state_d inside {ADDR, DATA}) ? !cur_bit :
                  (state_d == STOP) ? (q_d < 2'd2) : 1'b0;
   end
   // FSM and registered bus outputs advance once per tick; operands latched on leaving IDLE
   always_ff @(posedge clk100mhz or negedge res)
      if (!res) begin
         state <= IDLE;
         q <= '0;
         bit_cnt <= '0;
         ack <= 1'b0;
         addr_sh <= '0;
         data_sh <= '0;
         scl <= 1'b1;
         sda_low <= 1'b0;
      end else if (tick) begin
         state <= state_d;
         q <= q_d;
         bit_cnt <= bit_d;
         ack <= ack_d;
         scl <= scl_d;
         sda_low <= sda_low_d;
         if (state == IDLE) begin
            addr_sh <= addr_to_send;
            data_sh <= data_to_send;
         end
      end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: bus-level scoreboard bench for the single-shot I2C write master
`timescale 1ns/1ps
module tb_i2c_master;
   logic clk100mhz = 1'b0, res = 1'b0;
   logic scl, clk2mhz_dummy;
   logic [7:0] data_to_send = 8'h00, addr_to_send = 8'h00;
   wire sda;
   logic slave_low = 1'b0, ack_a = 1'b0, ack_d = 1'b0;
   logic prev_scl = 1'b1, prev_sda = 1'b1, cond = 1'b0;
   int falls = 0;
   int obs[$], exp_q[$];
   int compared = 0, mismatched = 0;
   time t_rel, p_time;

   i2c_master #(.QDIV(25)) dut (
      .clk100mhz(clk100mhz), .res(res), .sda(sda), .scl(scl),
      .data_to_send(data_to_send), .addr_to_send(addr_to_send), .clk2mhz_dummy(clk2mhz_dummy)
   );

   assign sda = slave_low ? 1'b0 : 1'bz;
   pullup (sda);
   always #5 clk100mhz = ~clk100mhz;

   // bus monitor and slave: 2 = START, 3 = STOP, 0/1 = bit seen during an scl high phase
   always @(negedge clk100mhz) begin
      if (res) begin
         if (scl && prev_scl && sda !== prev_sda) begin
            obs.push_back(sda ? 3 : 2);
            cond = 1'b1;
            if (!sda) falls = 0;
            else p_time = $time;
         end
         if (!scl && prev_scl) begin
            if (!cond) begin
               obs.push_back(int'(prev_sda));
               falls++;
            end
            cond = 1'b0;
            slave_low = (falls == 8 && ack_a) || (falls == 17 && ack_d);
         end
      end else begin
         cond = 1'b0;
         falls = 0;
         slave_low = 1'b0;
      end
      prev_scl = scl;
      prev_sda = sda;
   end

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
   endtask

   task automatic start_xfer(input logic [7:0] a, input logic [7:0] d, input logic aa, input logic ad);
      @(negedge clk100mhz);
      res = 1'b0;
      addr_to_send = a;
      data_to_send = d;
      ack_a = aa;
      ack_d = ad;
      #50;
      @(negedge clk100mhz);
      obs.delete();
      exp_q.delete();
      p_time = 0;
      res = 1'b1;
      t_rel = $time;
   endtask

   task automatic wait_events(input int n, output bit ok);
      for (int i = 0; i < 4000 && obs.size() < n; i++) @(negedge clk100mhz);
      ok = obs.size() >= n;
   endtask

   task automatic test_reset;
      bit ok;
      res = 1'b0;
      #50;
      compared += 3;
      if (scl !== 1'b1) begin mismatched++; $display("FAIL reset_scl: got %b, required 1", scl); end
      if (sda !== 1'b1) begin mismatched++; $display("FAIL reset_sda: got %b, required released(1)", sda); end
      if (clk2mhz_dummy !== 1'b0) begin mismatched++; $display("FAIL reset_dummy: got %b, required 0", clk2mhz_dummy); end
      start_xfer(8'h99, 8'h55, 1'b1, 1'b1);
      wait_events(3, ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL mid_reset_wait: got %0d events, required 3", obs.size()); end
      #2 res = 1'b0;
      #1;
      compared += 3;
      if (scl !== 1'b1) begin mismatched++; $display("FAIL mid_reset_scl: got %b, required 1", scl); end
      if (sda !== 1'b1) begin mismatched++; $display("FAIL mid_reset_sda: got %b, required released(1)", sda); end
      if (clk2mhz_dummy !== 1'b0) begin mismatched++; $display("FAIL mid_reset_dummy: got %b, required 0", clk2mhz_dummy); end
   endtask

   task automatic test_tick;
      time t0, t1;
      logic v;
      start_xfer(8'h99, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 400 && clk2mhz_dummy == 1'b0; i++) #1;
      t1 = $time;
      compared++;
      if (t1 - t_rel < 244 || t1 - t_rel > 247)
         begin mismatched++; $display("FAIL tick_first: got %0t ns, required 245 ns", t1 - t_rel); end
      for (int k = 0; k < 3; k++) begin
         t0 = t1;
         v = clk2mhz_dummy;
         for (int i = 0; i < 400 && clk2mhz_dummy == v; i++) #1;
         t1 = $time;
         compared++;
         if (t1 - t0 < 249 || t1 - t0 > 251)
            begin mismatched++; $display("FAIL tick_period %0d: got %0t ns, required 250 ns", k, t1 - t0); end
      end
   endtask

   task automatic test_ack_path;
      bit ok;
      int e, o, idx;
      logic v;
      start_xfer(8'h99, 8'h55, 1'b1, 1'b1);
      exp_q.push_back(2);
      push_byte(8'h99);
      exp_q.push_back(0);
      push_byte(8'h55);
      exp_q.push_back(0);
      exp_q.push_back(3);
      wait_events(exp_q.size(), ok);
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs.size() > 0 ? obs.pop_front() : -1;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL ack_path event %0d: got %0d, required %0d", idx, o, e); end
         idx++;
      end
      compared++;
      if (p_time - t_rel < 19740 || p_time - t_rel > 19760)
         begin mismatched++; $display("FAIL ack_stop_time: got %0t ns, required 19750 ns", p_time - t_rel); end
      repeat (200) @(negedge clk100mhz);
      compared += 3;
      if (scl !== 1'b1) begin mismatched++; $display("FAIL done_scl: got %b, required 1", scl); end
      if (sda !== 1'b1) begin mismatched++; $display("FAIL done_sda: got %b, required released(1)", sda); end
      if (obs.size() != 0) begin mismatched++; $display("FAIL done_extra: got %0d extra events, required 0", obs.size()); end
      v = clk2mhz_dummy;
      repeat (25) @(negedge clk100mhz);
      compared++;
      if (clk2mhz_dummy !== ~v) begin mismatched++; $display("FAIL done_dummy: got %b, required %b", clk2mhz_dummy, ~v); end
   endtask

   task automatic test_nack_path;
      bit ok;
      int e, o, idx;
      start_xfer(8'h99, 8'h55, 1'b0, 1'b0);
      exp_q.push_back(2);
      push_byte(8'h99);
      exp_q.push_back(1);
      exp_q.push_back(3);
      wait_events(exp_q.size(), ok);
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs.size() > 0 ? obs.pop_front() : -1;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL nack_path event %0d: got %0d, required %0d", idx, o, e); end
         idx++;
      end
      compared++;
      if (p_time - t_rel < 10740 || p_time - t_rel > 10760)
         begin mismatched++; $display("FAIL nack_stop_time: got %0t ns, required 10750 ns", p_time - t_rel); end
      repeat (200) @(negedge clk100mhz);
      compared += 3;
      if (scl !== 1'b1) begin mismatched++; $display("FAIL nack_scl: got %b, required 1", scl); end
      if (sda !== 1'b1) begin mismatched++; $display("FAIL nack_sda: got %b, required released(1)", sda); end
      if (obs.size() != 0) begin mismatched++; $display("FAIL nack_extra: got %0d extra events, required 0", obs.size()); end
   endtask

   task automatic test_input_stability;
      bit ok;
      int e, o, idx;
      start_xfer(8'h3C, 8'h55, 1'b1, 1'b1);
      exp_q.push_back(2);
      push_byte(8'h3C);
      exp_q.push_back(0);
      push_byte(8'h55);
      exp_q.push_back(0);
      exp_q.push_back(3);
      wait_events(4, ok);
      data_to_send = 8'hAA;
      addr_to_send = 8'hFF;
      wait_events(exp_q.size(), ok);
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs.size() > 0 ? obs.pop_front() : -1;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL stability event %0d: got %0d, required %0d", idx, o, e); end
         idx++;
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int e, o, idx;
      logic [7:0] a[2] = '{8'hA4, 8'h5A};
      logic [7:0] d[2] = '{8'h0F, 8'hF0};
      logic       ad[2] = '{1'b0, 1'b1};
      for (int r = 0; r < 2; r++) begin
         start_xfer(a[r], d[r], 1'b1, ad[r]);
         exp_q.push_back(2);
         push_byte(a[r]);
         exp_q.push_back(0);
         push_byte(d[r]);
         exp_q.push_back(ad[r] ? 0 : 1);
         exp_q.push_back(3);
         wait_events(exp_q.size(), ok);
         idx = 0;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs.size() > 0 ? obs.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL back_to_back run %0d event %0d: got %0d, required %0d", r, idx, o, e); end
            idx++;
         end
      end
   endtask

   initial begin
      test_reset;
      test_tick;
      test_ack_path;
      test_nack_path;
      test_input_stability;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
